// File: rtl/vector_operand_packer.sv
// Gathers scalar operand triples into lane-packed vectors for the MAC stage.
// One element per beat; a vector completes on the last lane or on in_last.
module vector_operand_packer #(
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 7,
    parameter int VECTOR  = 8,
    parameter int I_WIDTH = E_WIDTH + M_WIDTH + 1,
    parameter int VLEN    = I_WIDTH * VECTOR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [I_WIDTH-1:0] in_a,
    input  logic [I_WIDTH-1:0] in_b,
    input  logic [I_WIDTH-1:0] in_c,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VLEN-1:0]    a_out,
    output logic [VLEN-1:0]    b_out,
    output logic [VLEN-1:0]    c_out,
    output logic [VECTOR-1:0]  lane_mask,
    output logic [15:0]        vec_count
);
    localparam int CW = (VECTOR > 1) ? $clog2(VECTOR) : 1;

    typedef enum logic {S_FILL, S_HOLD} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [VLEN-1:0]   r_asm_a, r_asm_b, r_asm_c;
    logic [VECTOR-1:0] r_asm_mask;
    logic [VLEN-1:0]   r_out_a, r_out_b, r_out_c;
    logic [VECTOR-1:0] r_out_mask;
    logic              r_out_valid;
    logic [15:0]       r_vec_count;

    logic [VLEN-1:0]   w_wr_a, w_wr_b, w_wr_c;
    logic [VECTOR-1:0] w_wr_mask;
    logic              w_accept, w_complete, w_slot_free;
    logic              w_load_out, w_clear_asm;

    assign w_accept    = in_valid && in_ready;
    assign w_complete  = w_accept && ((r_cnt == CW'(VECTOR - 1)) || in_last);
    assign w_slot_free = !r_out_valid || out_ready;

    // Assembly buffer with the current beat merged in. In HOLD nothing is
    // accepted, so this equals the held vector and serves both load paths.
    for (genvar k = 0; k < VECTOR; k++) begin : g_lane
        logic w_sel;
        assign w_sel = w_accept && (r_cnt == CW'(k));
        assign w_wr_a[k*I_WIDTH +: I_WIDTH] = w_sel ? in_a : r_asm_a[k*I_WIDTH +: I_WIDTH];
        assign w_wr_b[k*I_WIDTH +: I_WIDTH] = w_sel ? in_b : r_asm_b[k*I_WIDTH +: I_WIDTH];
        assign w_wr_c[k*I_WIDTH +: I_WIDTH] = w_sel ? in_c : r_asm_c[k*I_WIDTH +: I_WIDTH];
        assign w_wr_mask[k] = w_sel | r_asm_mask[k];
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == S_FILL);
        w_load_out  = 1'b0;
        w_clear_asm = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_complete) begin
                    if (w_slot_free) begin
                        w_load_out  = 1'b1;
                        w_clear_asm = 1'b1;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_slot_free) begin
                    w_load_out  = 1'b1;
                    w_clear_asm = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_cnt       <= '0;
            r_asm_a     <= '0;
            r_asm_b     <= '0;
            r_asm_c     <= '0;
            r_asm_mask  <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_c     <= '0;
            r_out_mask  <= '0;
            r_out_valid <= 1'b0;
            r_vec_count <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_clear_asm) begin
                r_asm_a    <= '0;
                r_asm_b    <= '0;
                r_asm_c    <= '0;
                r_asm_mask <= '0;
                r_cnt      <= '0;
            end else begin
                r_asm_a    <= w_wr_a;
                r_asm_b    <= w_wr_b;
                r_asm_c    <= w_wr_c;
                r_asm_mask <= w_wr_mask;
                // A completed vector waiting in HOLD keeps cnt parked until it leaves.
                if (w_accept && !w_complete)
                    r_cnt <= r_cnt + 1'b1;
            end

            if (w_load_out) begin
                r_out_a     <= w_wr_a;
                r_out_b     <= w_wr_b;
                r_out_c     <= w_wr_c;
                r_out_mask  <= w_wr_mask;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (r_out_valid && out_ready)
                r_vec_count <= r_vec_count + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign a_out     = r_out_a;
    assign b_out     = r_out_b;
    assign c_out     = r_out_c;
    assign lane_mask = r_out_mask;
    assign vec_count = r_vec_count;

endmodule

// File: tb/tb_vector_operand_packer.sv
// Directed bench for vector_operand_packer at the default 8-lane, 16-bit element shape.
module tb_vector_operand_packer;
    localparam int IW = 16;
    localparam int NV = 8;
    localparam int VL = IW * NV;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [IW-1:0] in_a, in_b, in_c;
    logic          out_valid, out_ready;
    logic [VL-1:0] a_out, b_out, c_out;
    logic [NV-1:0] lane_mask;
    logic [15:0]   vec_count;

    int n_vec = 0;
    int n_err = 0;

    vector_operand_packer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .c_out(c_out),
        .lane_mask(lane_mask), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] a, input logic [IW-1:0] b,
                         input logic [IW-1:0] c, input logic last);
        in_valid = v; in_a = a; in_b = b; in_c = c; in_last = last;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (lane_mask !== '0) begin n_err++; $display("FAIL reset_lane_mask got %h want 00", lane_mask); end
        n_vec++; if (a_out !== '0 || b_out !== '0 || c_out !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", a_out); end
        n_vec++; if (vec_count !== 16'd0) begin n_err++; $display("FAIL reset_vec_count got %h want 0000", vec_count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_full();
        logic [IW-1:0] ea, eb, ec;
        out_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            drive(1'b1, 16'h3F80 + 16'(k), 16'h4000 + 16'(k), 16'h1000 + 16'(k), 1'b0);
            tick();
            if (k == NV - 2) begin
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_early_valid got %b want 0", out_valid); end
            end
        end
        idle();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid got %b want 1", out_valid); end
        n_vec++; if (lane_mask !== 8'hFF) begin n_err++; $display("FAIL full_mask got %h want ff", lane_mask); end
        for (int k = 0; k < NV; k++) begin
            ea = 16'h3F80 + 16'(k); eb = 16'h4000 + 16'(k); ec = 16'h1000 + 16'(k);
            n_vec++;
            if (a_out[k*IW +: IW] !== ea || b_out[k*IW +: IW] !== eb || c_out[k*IW +: IW] !== ec) begin
                n_err++;
                $display("FAIL full_lane%0d got %h/%h/%h want %h/%h/%h", k,
                         a_out[k*IW +: IW], b_out[k*IW +: IW], c_out[k*IW +: IW], ea, eb, ec);
            end
        end
        tick();
        n_vec++; if (vec_count !== 16'd1) begin n_err++; $display("FAIL full_vec_count got %h want 0001", vec_count); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_valid_fall got %b want 0", out_valid); end
    endtask

    task automatic test_partial();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'hA000 + 16'(k), 16'hB000 + 16'(k), 16'hC000 + 16'(k), k == 2);
            tick();
        end
        idle();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL partial_valid got %b want 1", out_valid); end
        n_vec++; if (lane_mask !== 8'h07) begin n_err++; $display("FAIL partial_mask got %h want 07", lane_mask); end
        n_vec++; if (a_out[2*IW +: IW] !== 16'hA002 || c_out[0 +: IW] !== 16'hC000) begin n_err++; $display("FAIL partial_written got %h/%h want a002/c000", a_out[2*IW +: IW], c_out[0 +: IW]); end
        n_vec++; if (a_out[VL-1:3*IW] !== '0 || b_out[VL-1:3*IW] !== '0 || c_out[VL-1:3*IW] !== '0) begin n_err++; $display("FAIL partial_zero_lanes got %h want 0", a_out[VL-1:3*IW]); end
        tick();
        drive(1'b1, 16'h5555, 16'h6666, 16'h7777, 1'b1);
        tick();
        idle();
        n_vec++; if (lane_mask !== 8'h01 || a_out[0 +: IW] !== 16'h5555) begin n_err++; $display("FAIL partial_restart got mask %h lane0 %h want 01 5555", lane_mask, a_out[0 +: IW]); end
        tick();
        n_vec++; if (vec_count !== 16'd3) begin n_err++; $display("FAIL partial_vec_count got %h want 0003", vec_count); end
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 2 * NV; k++) begin
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_beat%0d got %b want 1", k, in_ready); end
            drive(1'b1, 16'h2000 + 16'(k), 16'h3000 + 16'(k), 16'h4000 + 16'(k), 1'b0);
            tick();
            if (k >= NV && (a_out[0 +: IW] !== 16'h2000 || a_out[7*IW +: IW] !== 16'h2007 ||
                            lane_mask !== 8'hFF || out_valid !== 1'b1)) unstable++;
        end
        n_vec++; if (unstable != 0) begin n_err++; $display("FAIL bp_hold_stable got %0d changed cycles want 0", unstable); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready got %b want 0", in_ready); end
        // Offered while stalled: must be ignored.
        drive(1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 1'b1);
        tick(); tick();
        n_vec++; if (a_out[0 +: IW] !== 16'h2000 || vec_count !== 16'd3) begin n_err++; $display("FAIL bp_stall_state got %h cnt %h want 2000 0003", a_out[0 +: IW], vec_count); end
        idle();
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b1 || a_out[0 +: IW] !== 16'h2008 || a_out[7*IW +: IW] !== 16'h200F) begin n_err++; $display("FAIL bp_second_vec got v%b %h..%h want v1 2008..200f", out_valid, a_out[0 +: IW], a_out[7*IW +: IW]); end
        n_vec++; if (vec_count !== 16'd4) begin n_err++; $display("FAIL bp_first_handshake got %h want 0004", vec_count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_back got %b want 1", in_ready); end
        tick();
        n_vec++; if (vec_count !== 16'd5 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %h v%b want 0005 v0", vec_count, out_valid); end
    endtask

    task automatic test_reset_midfill();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'hEEE0 + 16'(k), '0, '0, 1'b0);
            tick();
        end
        do_reset();
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0 || lane_mask !== '0) begin n_err++; $display("FAIL midfill_discard got v%b mask %h want v0 00", out_valid, lane_mask); end
        for (int k = 0; k < NV; k++) begin
            drive(1'b1, 16'h1100 + 16'(k), '0, '0, 1'b0);
            tick();
        end
        idle();
        n_vec++; if (lane_mask !== 8'hFF || a_out[0 +: IW] !== 16'h1100 || a_out[7*IW +: IW] !== 16'h1107) begin n_err++; $display("FAIL midfill_next_vec got mask %h %h..%h want ff 1100..1107", lane_mask, a_out[0 +: IW], a_out[7*IW +: IW]); end
        tick();
        n_vec++; if (vec_count !== 16'd1) begin n_err++; $display("FAIL midfill_vec_count got %h want 0001", vec_count); end
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        int vecs = 0;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            drive(1'b1, 16'(k), 16'(k + 100), 16'(k + 200), 1'b0);
            if (in_ready !== 1'b1) stalls++;
            tick();
            if (out_valid === 1'b1) vecs++;
        end
        idle();
        tick();
        n_vec++; if (stalls != 0) begin n_err++; $display("FAIL stream_stalls got %0d want 0", stalls); end
        n_vec++; if (vecs != 8) begin n_err++; $display("FAIL stream_vectors got %0d want 8", vecs); end
        n_vec++; if (vec_count !== 16'd8) begin n_err++; $display("FAIL stream_vec_count got %h want 0008", vec_count); end
        n_vec++; if (a_out[7*IW +: IW] !== 16'd63) begin n_err++; $display("FAIL stream_last_lane got %h want 003f", a_out[7*IW +: IW]); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        // One single-lane vector per cycle; 65535 beats then an idle cycle = 65535 handshakes.
        drive(1'b1, 16'h0001, 16'h0002, 16'h0003, 1'b1);
        for (int k = 0; k < 65535; k++) tick();
        idle();
        tick();
        n_vec++; if (vec_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload got %h want ffff", vec_count); end
        drive(1'b1, 16'h0004, 16'h0005, 16'h0006, 1'b1);
        tick();
        idle();
        tick();
        n_vec++; if (vec_count !== 16'h0000) begin n_err++; $display("FAIL wrap_rollover got %h want 0000", vec_count); end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle();
        test_reset();
        test_full();
        test_partial();
        test_backpressure();
        test_reset_midfill();
        test_back_to_back();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
